sseg_frame_arbiter: RTL and testbench
=====================================

# sseg_frame_arbiter

Shares the serial seven-segment shift chain (ss_dout/ss_clk/ss_en, 64-bit frame, 8 digits × 8 segment bits) between NREQ independent requesters. Each requester offers a 32-bit hex value through a valid/ready handshake. A round-robin arbiter grants one requester per frame. The block decodes the value to active-low segment bytes, shifts the frame out MSB-first with a divided ss_clk, then pulses ss_en to latch the display. It sits between the application logic and the board's display pins.

## Interface
- NREQ, default 2: number of requesters, 1..8.
- CLK_DIV, default 4: clk cycles per ss_clk half-period, ≥1.
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- req_valid  in  NREQ  requester i has a value pending.
- req_data  in  32*NREQ  requester i value in bits [32i+31:32i]; hex digit 7 = bits [31:28].
- req_ready  out  NREQ  one-hot accept strobe.
- busy  out  1  frame in progress.
- grant_id  out  clog2(NREQ) (min 1)  requester owning the current or last frame.
- ss_dout  out  1  serial segment data.
- ss_clk  out  1  shift clock; the chain samples on the rising edge.
- ss_en  out  1  latch strobe; the chain latches on the rising edge.

## Operation
- States: IDLE, SHIFT, LATCH.
- IDLE:
  - Round-robin search starts at requester (last_grant+1) mod NREQ and wraps.
  - req_ready is combinational and is high only for the first valid requester found. It is low for all requesters when none is valid.
  - On the handshake edge (valid & ready), load the 64-bit frame, set grant_id and last_grant, go to SHIFT, and set busy=1.
- Frame layout:
  - frame[63:56] = seg(digit 7) … frame[7:0] = seg(digit 0).
  - Each byte is {dp,g,f,e,d,c,b,a}, active-low; dp is always 1 (off).
- seg() table for 0–F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E. Blank = FF.
- SHIFT:
  - ss_dout presents frame[63] first.
  - The frame shifts left by one bit on each ss_clk falling edge.
  - After 64 rising edges, go to LATCH.
- LATCH: ss_en is high for CLK_DIV cycles, then return to IDLE with busy=0.
- No requester is accepted while busy. Requesters hold valid and data until ready.
- Reset values: ss_dout=0, ss_clk=0, ss_en=0, busy=0, req_ready=0, grant_id=0. last_grant resets to NREQ-1, so requester 0 has first priority.
- A reset mid-frame aborts immediately:
  - ss_en does not rise for that frame.
  - The display keeps its previously latched contents.

## Timing
- E0 = handshake edge. From E0: ss_clk=0 and ss_dout=frame[63].
- Bit k (k=0..63):
  - ss_clk rises at E0+(2k+1)·CLK_DIV.
  - ss_clk falls at E0+(2k+2)·CLK_DIV, and ss_dout advances on that same edge.
- ss_en rises at E0+128·CLK_DIV and falls at E0+129·CLK_DIV. At that same edge: state=IDLE, busy=0, ss_clk=0.
- The earliest next handshake is edge E0+129·CLK_DIV+1. The minimum frame period is 129·CLK_DIV+1 cycles.
- ss_dout is stable for a full CLK_DIV before and after every ss_clk rising edge.
- A requester that stays valid waits at most NREQ-1 frames.

## Configuration
- SSEG_LZ_BLANK_EN:
  - Defined: leading zero digits, from digit 7 downward, encode as FF. Digit 0 always displays, so all-zero data gives FF…FF C0.
  - Undefined: every digit is decoded, with no blanking logic.
- Blanking is computed combinationally at load time and adds no latency.

## Structure
- Package sseg_pkg holds:
  - the state enum;
  - FRAME_BITS=64 and SEG_BLANK=8'hFF;
  - the hex-to-segment function;
  - the leading-zero mask function.
- Sub-module sseg_rr_arbiter (NREQ): inputs req_valid, last_grant, enable; outputs one-hot grant and encoded grant id.
- The top contains the FSM, CLK_DIV tick counter, 6-bit bit counter and frame shift register.

## Test plan
- NREQ=1, CLK_DIV=1, req_data=32'h01234567:
  - the receiver shift register captured on ss_en rise = 64'hC0F9A4B0999282F8;
  - ss_en rises 128 cycles after the handshake.
- NREQ=2, both requesters continuously valid with 32'h11111111 and 32'h22222222:
  - grants alternate 0,1,0,1;
  - latched frames alternate F9F9F9F9F9F9F9F9 and A4A4A4A4A4A4A4A4.
- CLK_DIV=3:
  - ss_clk high and low phases are exactly 3 cycles each;
  - ss_en is high for 3 cycles;
  - req_ready stays 0 while busy, even with valid held high.
- Reset asserted at bit 20 of a frame:
  - all outputs return to reset values on the next edge;
  - no ss_en pulse occurs;
  - after release, requester 0 is granted first.
- 32'h00000A05:
  - with SSEG_LZ_BLANK_EN defined, the frame is FFFFFFFFFF88C092;
  - without it, the frame is C0C0C0C0C088C092;
  - with the macro defined, 32'h0 gives FFFFFFFFFFFFFFC0.

Source files
------------

// File: rtl/sseg_pkg.sv
// +----------------------------------------------------------------------------+
// | sseg_pkg: shared types, constants and segment helpers for the sseg display  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int         FRAME_BITS = 64;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is held off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  // Bit d set when digit d is a leading zero; digit 0 is never blanked.
  function automatic logic [7:0] lz_mask(input logic [31:0] value);
    logic [7:0] mask;
    logic       run;
    mask = '0;
    run  = 1'b1;
    for (int d = 7; d >= 1; d--) begin
      if (run && (value[4*d +: 4] == 4'h0)) begin
        mask[d] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sseg_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | sseg_rr_arbiter: round-robin pick of one valid requester after last_grant   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module sseg_rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [GW-1:0]   last_grant,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [GW-1:0]   grant_id
);

  always_comb begin
    int   start;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    start    = (int'(last_grant) + 1) % NREQ;
    for (int o = 0; o < NREQ; o++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (enable && !found && req_valid[j] && (((start + o) % NREQ) == j)) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          grant_id = GW'(j);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sseg_frame_arbiter.sv
// +----------------------------------------------------------------------------+
// | sseg_frame_arbiter: arbitrates requesters onto a serial 8-digit 7-seg chain |
// | Option: SSEG_LZ_BLANK_EN blanks leading zero digits.  Revision: 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module sseg_frame_arbiter
  import sseg_pkg::*;
#(
  parameter  int NREQ    = 2,
  parameter  int CLK_DIV = 4,
  localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              busy,
  output logic [GW-1:0]     grant_id,
  output logic              ss_dout,
  output logic              ss_clk,
  output logic              ss_en
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t                  state, state_next;
  logic [DW-1:0]           div_cnt, div_next;
  logic [5:0]              bit_cnt, bit_next;
  logic [FRAME_BITS-1:0]   frame, frame_next, load_frame;
  logic                    sclk_next, en_next;
  logic [GW-1:0]           gid_next, last_grant, last_next;
  logic [NREQ-1:0]         grant;
  logic [GW-1:0]           arb_id;
  logic [31:0]             sel_data;
  logic                    arb_en, handshake, tick;

  // Ready is held low during reset so nothing is accepted before release.
  assign arb_en    = (state == IDLE) && rstn;
  assign handshake = |grant;
  assign req_ready = grant;
  assign busy      = (state != IDLE);
  assign ss_dout   = frame[FRAME_BITS-1];
  assign tick      = (div_cnt == DW'(CLK_DIV - 1));

  sseg_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .enable     (arb_en),
    .grant      (grant),
    .grant_id   (arb_id)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | req_data[32*i +: 32];
      end
    end
  end

`ifdef SSEG_LZ_BLANK_EN
  logic [7:0] blank;
  assign blank = lz_mask(sel_data);
`endif

  always_comb begin
    load_frame = '0;
    for (int d = 0; d < 8; d++) begin
      load_frame[8*d +: 8] = hex_to_seg(sel_data[4*d +: 4]);
`ifdef SSEG_LZ_BLANK_EN
      if (blank[d]) begin
        load_frame[8*d +: 8] = SEG_BLANK;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      frame      <= '0;
      ss_clk     <= 1'b0;
      ss_en      <= 1'b0;
      grant_id   <= '0;
      last_grant <= GW'(NREQ - 1);
    end else begin
      state      <= state_next;
      div_cnt    <= div_next;
      bit_cnt    <= bit_next;
      frame      <= frame_next;
      ss_clk     <= sclk_next;
      ss_en      <= en_next;
      grant_id   <= gid_next;
      last_grant <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_cnt;
    frame_next = frame;
    sclk_next  = ss_clk;
    en_next    = ss_en;
    gid_next   = grant_id;
    last_next  = last_grant;
    case (state)
      IDLE: begin
        div_next  = '0;
        sclk_next = 1'b0;
        en_next   = 1'b0;
        if (handshake) begin
          frame_next = load_frame;
          gid_next   = arb_id;
          last_next  = arb_id;
          bit_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          div_next = '0;
          if (!ss_clk) begin
            sclk_next = 1'b1;
          end else begin
            // Falling edge: advance data; the 64th fall also opens the latch window.
            sclk_next  = 1'b0;
            frame_next = {frame[FRAME_BITS-2:0], 1'b0};
            bit_next   = bit_cnt + 6'd1;
            if (bit_cnt == 6'd63) begin
              state_next = LATCH;
              en_next    = 1'b1;
            end
          end
        end else begin
          div_next = div_cnt + DW'(1);
        end
      end
      LATCH: begin
        if (tick) begin
          div_next   = '0;
          en_next    = 1'b0;
          state_next = IDLE;
        end else begin
          div_next = div_cnt + DW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sseg_frame_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_sseg_frame_arbiter: directed checks of framing, arbitration and reset    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sseg_frame_arbiter;

`ifdef SSEG_LZ_BLANK_EN
  localparam logic [63:0] EXP_A05  = 64'hFFFFFFFFFF88C092;
  localparam logic [63:0] EXP_ZERO = 64'hFFFFFFFFFFFFFFC0;
`else
  localparam logic [63:0] EXP_A05  = 64'hC0C0C0C0C088C092;
  localparam logic [63:0] EXP_ZERO = 64'hC0C0C0C0C0C0C0C0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn1, valid1, ready1, busy1, gid1, dout1, sclk1, en1;
  logic [31:0] data1;
  logic        rstn2, busy2, gid2, dout2, sclk2, en2;
  logic [1:0]  valid2, ready2;
  logic [63:0] data2;

  int checks = 0;
  int errors = 0;

  sseg_frame_arbiter #(.NREQ(1), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rstn(rstn1), .req_valid(valid1), .req_data(data1),
    .req_ready(ready1), .busy(busy1), .grant_id(gid1),
    .ss_dout(dout1), .ss_clk(sclk1), .ss_en(en1)
  );

  sseg_frame_arbiter #(.NREQ(2), .CLK_DIV(3)) u_dut2 (
    .clk(clk), .rstn(rstn2), .req_valid(valid2), .req_data(data2),
    .req_ready(ready2), .busy(busy2), .grant_id(gid2),
    .ss_dout(dout2), .ss_clk(sclk2), .ss_en(en2)
  );

  // Receiver side of each display chain.
  logic [63:0] rx1 = '0, lat1 = '0, rx2 = '0, lat2 = '0;
  int en_cnt2 = 0;
  always @(posedge sclk1) rx1 <= {rx1[62:0], dout1};
  always @(posedge en1)   lat1 <= rx1;
  always @(posedge sclk2) rx2 <= {rx2[62:0], dout2};
  always @(posedge en2) begin
    lat2    <= rx2;
    en_cnt2 <= en_cnt2 + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic frame1(input string tag, input logic [31:0] d, input logic [63:0] exp);
    int n;
    data1  = d;
    valid1 = 1'b1;
    #1;
    n = 0;
    while (ready1 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, "_ready"}, 64'(ready1), 64'd1);
    @(posedge clk); #1;
    valid1 = 1'b0;
    check({tag, "_busy"}, 64'(busy1), 64'd1);
    check({tag, "_first_bit"}, 64'(dout1), 64'(exp[63]));
    n = 0;
    while (en1 !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    check({tag, "_en_latency"}, 64'(n), 64'd128);
    while (en1 === 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    check({tag, "_frame"}, lat1, exp);
    check({tag, "_idle"}, 64'(busy1), 64'd0);
  endtask

  task automatic frame2(input int exp_id, input logic [63:0] exp_frame);
    int n, run, rises, en_len, bad, rdy_busy;
    logic prev, en_seen;
    logic [1:0] er;
    er = '0;
    er[exp_id] = 1'b1;
    n = 0;
    while (ready2 == 2'b00 && n < 50) begin @(posedge clk); #1; n++; end
    check("arb_ready", 64'(ready2), 64'(er));
    @(posedge clk); #1;
    check("arb_gid", 64'(gid2), 64'(exp_id));
    n = 0; run = 1; prev = sclk2; rises = 0; en_len = 0; bad = 0; rdy_busy = 0; en_seen = 1'b0;
    while (busy2 === 1'b1 && n < 2000) begin
      @(posedge clk); #1; n++;
      if (sclk2 !== prev) begin
        if (!en_seen && run != 3) bad++;
        if (sclk2 === 1'b1) rises++;
        run  = 1;
        prev = sclk2;
      end else begin
        run++;
      end
      if (en2 === 1'b1) begin
        en_seen = 1'b1;
        en_len++;
      end
      if (busy2 === 1'b1 && ready2 != 2'b00) rdy_busy++;
    end
    check("frame_len", 64'(n), 64'd387);
    check("clk_phase", 64'(bad), 64'd0);
    check("clk_rises", 64'(rises), 64'd64);
    check("en_len", 64'(en_len), 64'd3);
    check("ready_busy", 64'(rdy_busy), 64'd0);
    check("latched", lat2, exp_frame);
  endtask

  initial begin
    int n, rises, en_before;
    logic prev;
    rstn1 = 1'b0; rstn2 = 1'b0;
    valid1 = 1'b0; valid2 = 2'b00;
    data1 = '0; data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 64'(dout2), 64'd0);
    check("rst_sclk", 64'(sclk2), 64'd0);
    check("rst_en", 64'(en2), 64'd0);
    check("rst_busy", 64'(busy2), 64'd0);
    check("rst_ready", 64'(ready2), 64'd0);
    check("rst_gid", 64'(gid2), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    rstn1 = 1'b1; rstn2 = 1'b1;
    @(posedge clk); #1;

    frame1("digits", 32'h01234567, 64'hC0F9A4B0999282F8);
    frame1("a05", 32'h00000A05, EXP_A05);
    frame1("zero", 32'h00000000, EXP_ZERO);

    data2  = {32'h22222222, 32'h11111111};
    valid2 = 2'b11;
    #1;
    frame2(0, 64'hF9F9F9F9F9F9F9F9);
    frame2(1, 64'hA4A4A4A4A4A4A4A4);
    frame2(0, 64'hF9F9F9F9F9F9F9F9);
    frame2(1, 64'hA4A4A4A4A4A4A4A4);

    // Abort a frame owned by requester 0 partway through bit 20.
    valid2 = 2'b01;
    #1;
    n = 0;
    while (ready2 == 2'b00 && n < 50) begin @(posedge clk); #1; n++; end
    check("abort_ready", 64'(ready2), 64'd1);
    @(posedge clk); #1;
    rises = 0; n = 0; prev = sclk2;
    while (rises < 20 && n < 2000) begin
      @(posedge clk); #1; n++;
      if (sclk2 === 1'b1 && prev === 1'b0) rises++;
      prev = sclk2;
    end
    check("abort_bit20", 64'(rises), 64'd20);
    check("abort_midframe_busy", 64'(busy2), 64'd1);
    en_before = en_cnt2;
    rstn2  = 1'b0;
    valid2 = 2'b11;
    @(posedge clk); #1;
    check("abort_dout", 64'(dout2), 64'd0);
    check("abort_sclk", 64'(sclk2), 64'd0);
    check("abort_en", 64'(en2), 64'd0);
    check("abort_busy", 64'(busy2), 64'd0);
    check("abort_ready_rst", 64'(ready2), 64'd0);
    check("abort_gid", 64'(gid2), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    rstn2 = 1'b1;
    #1;
    check("post_rst_ready", 64'(ready2), 64'd1);
    @(posedge clk); #1;
    check("post_rst_gid", 64'(gid2), 64'd0);
    check("post_rst_busy", 64'(busy2), 64'd1);
    repeat (100) @(posedge clk);
    #1;
    check("abort_no_latch", 64'(en_cnt2), 64'(en_before));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
